// File: rtl/rr_arbiter_8ch.sv
// rr_arbiter_8ch: 8-client round-robin arbiter with hold-until-release and hold-time budget
module rr_arbiter_8ch #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, idx, idx_n, nxt_ptr, win;
  logic [7:0] cnt, cnt_n;
  logic tmo, tmo_n, hold_hit, done;
  // rotate right by p, take the lowest set bit, then rotate the index back
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] d;
    logic [2:0] l;
    d = {r, r} >> p;
    l = 3'd0;
    for (int i = 7; i >= 0; i--) if (d[i]) l = 3'(i);
    return l + p;
  endfunction
  assign hold_hit = (HOLD_MAX != 0) && (cnt == HOLD_LAST);
  assign done = release_i || !req_i[idx] || hold_hit;
  assign nxt_ptr = idx + 3'd1;
  assign win = pick(req_i, state == GRANT ? nxt_ptr : ptr);
  // state, pointer, owner index, hold counter and timeout pulse registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      ptr <= 3'd0;
      idx <= 3'd0;
      cnt <= 8'd0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      idx <= idx_n;
      cnt <= cnt_n;
      tmo <= tmo_n;
    end
  // next state: grant from idle, hand over directly on grant end, otherwise count hold cycles
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    idx_n = idx;
    cnt_n = cnt;
    tmo_n = 1'b0;
    if (state == IDLE) begin
      state_n = |req_i ? GRANT : IDLE;
      idx_n = |req_i ? win : 3'd0;
      cnt_n = 8'd0;
    end else if (done) begin
      ptr_n = nxt_ptr;
      tmo_n = hold_hit && !release_i && req_i[idx];
      state_n = |req_i ? GRANT : IDLE;
      idx_n = |req_i ? win : 3'd0;
      cnt_n = 8'd0;
    end else begin
      cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end
  end
  // outputs decoded from registered state only
  always_comb begin
    gnt_valid_o = state == GRANT;
    gnt_idx_o = idx;
    gnt_o = gnt_valid_o ? 8'(1) << idx : 8'd0;
    timeout_o = tmo;
  end
endmodule

// File: tb/tb_rr_arbiter_8ch.sv
// tb_rr_arbiter_8ch: scoreboard bench for rr_arbiter_8ch at HOLD_MAX 16, 4 and 0
module tb_rr_arbiter_8ch;
  typedef struct {
    int d;
    logic v;
    logic [2:0] i;
    logic t;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req [3];
  logic rel [3];
  logic [7:0] gnt [3];
  logic [2:0] gidx [3];
  logic gval [3];
  logic tmo [3];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rr_arbiter_8ch #(.HOLD_MAX(16)) dut_a (.clk_i(clk), .rst_i(rst), .req_i(req[0]), .release_i(rel[0]),
    .gnt_o(gnt[0]), .gnt_idx_o(gidx[0]), .gnt_valid_o(gval[0]), .timeout_o(tmo[0]));
  rr_arbiter_8ch #(.HOLD_MAX(4)) dut_b (.clk_i(clk), .rst_i(rst), .req_i(req[1]), .release_i(rel[1]),
    .gnt_o(gnt[1]), .gnt_idx_o(gidx[1]), .gnt_valid_o(gval[1]), .timeout_o(tmo[1]));
  rr_arbiter_8ch #(.HOLD_MAX(0)) dut_c (.clk_i(clk), .rst_i(rst), .req_i(req[2]), .release_i(rel[2]),
    .gnt_o(gnt[2]), .gnt_idx_o(gidx[2]), .gnt_valid_o(gval[2]), .timeout_o(tmo[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag, input int d);
    check({tag, " gnt"}, 32'(gnt[d]), 32'd0);
    check({tag, " idx"}, 32'(gidx[d]), 32'd0);
    check({tag, " valid"}, 32'(gval[d]), 32'd0);
    check({tag, " timeout"}, 32'(tmo[d]), 32'd0);
  endtask
  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      req[k] = 8'd0;
      rel[k] = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check_zero("reset", k);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic step(input string tag, input int d, input logic [7:0] r, input logic l,
                      input logic v, input logic [2:0] i, input logic t);
    exp_t e;
    req[d] = r;
    rel[d] = l;
    q.push_back('{d, v, i, t, tag});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({e.tag, " valid"}, 32'(gval[e.d]), 32'(e.v));
    check({e.tag, " idx"}, 32'(gidx[e.d]), 32'(e.i));
    check({e.tag, " gnt"}, 32'(gnt[e.d]), e.v ? 32'd1 << e.i : 32'd0);
    check({e.tag, " timeout"}, 32'(tmo[e.d]), 32'(e.t));
  endtask
  initial begin
    do_reset();
    step("rot first", 0, 8'h11, 1'b0, 1'b1, 3'd0, 1'b0);
    step("rot second", 0, 8'h11, 1'b1, 1'b1, 3'd4, 1'b0);
    step("rot wrap", 0, 8'h11, 1'b1, 1'b1, 3'd0, 1'b0);
    step("rot idle", 0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    step("idle release", 0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    do_reset();
    step("fair start", 0, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 1; k <= 8; k++) step("fair", 0, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 1'b0);
    do_reset();
    step("wd own5", 0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0);
    step("wd move1", 0, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0);
    step("wd regrant1", 0, 8'h02, 1'b1, 1'b1, 3'd1, 1'b0);
    step("wd idle", 0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    do_reset();
    step("lone first", 0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0);
    for (int k = 0; k < 3; k++) step("lone regrant", 0, 8'h80, 1'b1, 1'b1, 3'd7, 1'b0);
    do_reset();
    step("mid own3", 0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_zero("mid async", 0);
    @(posedge clk);
    #1;
    check_zero("mid held", 0);
    rst = 1'b0;
    step("mid regrant3", 0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0);
    do_reset();
    step("to own1", 1, 8'h06, 1'b0, 1'b1, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) step("to hold1", 1, 8'h06, 1'b0, 1'b1, 3'd1, 1'b0);
    step("to forced2", 1, 8'h06, 1'b0, 1'b1, 3'd2, 1'b1);
    for (int k = 0; k < 3; k++) step("to hold2", 1, 8'h06, 1'b0, 1'b1, 3'd2, 1'b0);
    step("to forced1", 1, 8'h06, 1'b0, 1'b1, 3'd1, 1'b1);
    for (int k = 0; k < 3; k++) step("to hold1b", 1, 8'h06, 1'b0, 1'b1, 3'd1, 1'b0);
    step("to rel at limit", 1, 8'h06, 1'b1, 1'b1, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) step("to hold2b", 1, 8'h06, 1'b0, 1'b1, 3'd2, 1'b0);
    step("to wd at limit", 1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0);
    do_reset();
    step("nt own0", 2, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 300; k++) step("nt hold", 2, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
